light_timer: RTL and testbench

//  Countdown timer that serves the traffic-light controller's timer interface
//  (timer_en / timer_load / timer_init / timer_out).
//  A prescaler divides clk down to a tick, one tick per second on the board.

---
 rtl/light_timer_pkg.sv | 27 ++
 rtl/light_timer_tick_prescaler.sv | 62 ++++++
 rtl/light_timer.sv | 93 +++++++++
 tb/tb_light_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/light_timer_pkg.sv
// ============================================================================
// Module   : light_timer_pkg
// Brief    : Shared state encoding, default tick divider and sizing helper
//            for the light_timer countdown block.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package light_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPIRED  = 2'd3
    } timer_state_e;

    // One tick per second from the 100 MHz board clock.
    localparam int unsigned C_DEFAULT_DIV = 100_000_000;

    function automatic int unsigned prescale_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/light_timer_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Divides clk by DIV while enabled; wrap flags the cycle whose
//            edge ends a period, tick is the registered one-cycle pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import light_timer_pkg::*;
#(
    parameter int unsigned DIV = C_DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic wrap,
    output logic tick
);

    localparam int unsigned       C_PW   = prescale_width(DIV);
    localparam logic [C_PW-1:0]   C_LAST = C_PW'(DIV - 1);

    logic [C_PW-1:0] r_cnt_q;
    logic [C_PW-1:0] w_cnt_d;
    logic            r_tick_q;
    logic            w_tick_d;

    // wrap is exposed unregistered so the count can decrement on the very
    // edge that ends the period, DIV cycles after a load.
    assign wrap = !clear && en && (r_cnt_q == C_LAST);
    assign tick = r_tick_q;

    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_tick_d = 1'b0;
        if (clear) begin
            w_cnt_d = '0;
        end else if (en) begin
            if (r_cnt_q == C_LAST) begin
                w_cnt_d  = '0;
                w_tick_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + C_PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt_q  <= '0;
            r_tick_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_tick_q <= w_tick_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/light_timer.sv
// ============================================================================
// Module   : light_timer
// Brief    : Loadable countdown timer for the traffic-light controller with
//            zero level, expiry pulse and debug state output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module light_timer
    import light_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_load,
    input  logic             timer_en,
    input  logic [WIDTH-1:0] timer_init,
    output logic [WIDTH-1:0] timer_out,
    output logic             timer_zero,
    output logic             timer_expired,
    output logic             tick,
    output logic [1:0]       timer_state
);

    logic             w_wrap;
    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             r_expired_q;
    logic             w_expired_d;
    timer_state_e     r_state_q;
    timer_state_e     w_state_d;

    tick_prescaler #(
        .DIV   (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_load),
        .en    (timer_en),
        .wrap  (w_wrap),
        .tick  (tick)
    );

    always_comb begin
        w_count_d   = r_count_q;
        w_expired_d = 1'b0;
        w_state_d   = r_state_q;
        if (timer_load) begin
            w_count_d = timer_init;
            if (timer_init == '0) begin
                w_state_d = ST_EXPIRED;
            end else begin
                w_state_d = timer_en ? ST_RUNNING : ST_PAUSED;
            end
        end else if (timer_en) begin
            if (r_state_q == ST_PAUSED) begin
                w_state_d = ST_RUNNING;
            end
            // Zero holds: ticks at zero neither wrap the count nor re-expire.
            if (w_wrap && (r_count_q != '0)) begin
                w_count_d = r_count_q - WIDTH'(1);
                if (r_count_q == WIDTH'(1)) begin
                    w_expired_d = 1'b1;
                    w_state_d   = ST_EXPIRED;
                end
            end
        end else if (r_state_q == ST_RUNNING) begin
            w_state_d = ST_PAUSED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count_q   <= '0;
            r_expired_q <= 1'b0;
            r_state_q   <= ST_IDLE;
        end else begin
            r_count_q   <= w_count_d;
            r_expired_q <= w_expired_d;
            r_state_q   <= w_state_d;
        end
    end

    assign timer_out     = r_count_q;
    assign timer_zero    = (r_count_q == '0);
    assign timer_expired = r_expired_q;
    assign timer_state   = r_state_q;

endmodule

`default_nettype wire

// File: tb/tb_light_timer.sv
// ============================================================================
// Module   : tb_light_timer
// Brief    : Directed scenarios plus randomized traffic for light_timer,
//            checked every cycle against an integer reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_light_timer;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;

    logic             clk;
    logic             rst;
    logic             timer_load;
    logic             timer_en;
    logic [WIDTH-1:0] timer_init;
    logic [WIDTH-1:0] timer_out;
    logic             timer_zero;
    logic             timer_expired;
    logic             tick;
    logic [1:0]       timer_state;

    light_timer #(
        .WIDTH         (WIDTH),
        .DIV           (DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .timer_load    (timer_load),
        .timer_en      (timer_en),
        .timer_init    (timer_init),
        .timer_out     (timer_out),
        .timer_zero    (timer_zero),
        .timer_expired (timer_expired),
        .tick          (tick),
        .timer_state   (timer_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: count value, enabled cycles since the last period
    // boundary, and the debug state number (0 idle, 1 run, 2 pause, 3 done).
    int m_count;
    int m_phase;
    int m_state;
    int m_tick;
    int m_exp;
    int pulses;
    int exp_cycle;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge();
        m_tick = 0;
        m_exp  = 0;
        if (!rst) begin
            m_count = 0;
            m_phase = 0;
            m_state = 0;
        end else if (timer_load) begin
            m_count = int'(timer_init);
            m_phase = 0;
            m_state = (m_count == 0) ? 3 : (timer_en ? 1 : 2);
        end else if (timer_en) begin
            if (m_state == 2) m_state = 1;
            m_phase = m_phase + 1;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_tick  = 1;
                if (m_count > 0) begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_exp   = 1;
                        m_state = 3;
                    end
                end
            end
        end else if (m_state == 1) begin
            m_state = 2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_value("timer_out",     32'(timer_out),     32'(m_count));
        check_value("timer_zero",    32'(timer_zero),    32'(m_count == 0));
        check_value("tick",          32'(tick),          32'(m_tick));
        check_value("timer_expired", 32'(timer_expired), 32'(m_exp));
        check_value("timer_state",   32'(timer_state),   32'(m_state));
        if (timer_expired === 1'b1) pulses++;
    endtask

    task automatic load_value(input int value, input logic en);
        timer_init = WIDTH'(value);
        timer_load = 1'b1;
        timer_en   = en;
        step();
        timer_load = 1'b0;
        pulses     = 0;
    endtask

    initial begin
        rst        = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_init = '0;
        m_count = 0; m_phase = 0; m_state = 0; m_tick = 0; m_exp = 0;
        pulses = 0; exp_cycle = -1;

        // Reset for two cycles
        step();
        step();
        rst = 1'b1;
        check_value("rst_out",   32'(timer_out),   32'd0);
        check_value("rst_zero",  32'(timer_zero),  32'd1);
        check_value("rst_state", 32'(timer_state), 32'd0);

        // Countdown from 3 with a single expiry pulse at cycle 12
        load_value(3, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (timer_expired === 1'b1) exp_cycle = i;
        end
        check_value("s2_pulses",    32'(pulses),    32'd1);
        check_value("s2_exp_cycle", 32'(exp_cycle), 32'd12);
        check_value("s2_out",       32'(timer_out), 32'd0);

        // Pause and resume
        load_value(5, 1'b1);
        repeat (2) step();
        timer_en = 1'b0;
        repeat (10) step();
        check_value("s3_paused",   32'(timer_state), 32'd2);
        check_value("s3_held",     32'(timer_out),   32'd5);
        timer_en = 1'b1;
        step();
        check_value("s3_resumed",  32'(timer_state), 32'd1);
        check_value("s3_no_dec",   32'(timer_out),   32'd5);
        step();
        check_value("s3_dec",      32'(timer_out),   32'd4);

        // Reload on the tick edge: load wins, prescaler restarts
        load_value(9, 1'b1);
        repeat (3) step();
        load_value(7, 1'b1);
        check_value("s4_reload",   32'(timer_out),   32'd7);
        repeat (3) step();
        check_value("s4_hold",     32'(timer_out),   32'd7);
        step();
        check_value("s4_dec",      32'(timer_out),   32'd6);

        // Load zero: expired state, never a pulse
        load_value(0, 1'b1);
        repeat (12) step();
        check_value("s5_pulses",   32'(pulses),      32'd0);
        check_value("s5_state",    32'(timer_state), 32'd3);
        check_value("s5_zero",     32'(timer_zero),  32'd1);

        // Reset mid-count; counting stays stopped until a new load
        load_value(6, 1'b1);
        repeat (16) step();
        check_value("s6_before",   32'(timer_out),   32'd2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_value("s6_rst_out",  32'(timer_out),   32'd0);
        repeat (8) step();
        check_value("s6_idle_out", 32'(timer_out),   32'd0);
        check_value("s6_idle_st",  32'(timer_state), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom % 64) != 0;
            timer_load = ($urandom % 10) == 0;
            timer_en   = ($urandom % 4) != 0;
            timer_init = WIDTH'($urandom % 6);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
